// File: rtl/ddr_types_pkg.sv
// ddr_types_pkg: shared types and default constants for the DDR QoS credit path.
package ddr_types_pkg;

  localparam int CLS_W        = 2;
  localparam int DEF_COALESCE = 4;
  localparam int DEF_TIMEOUT  = 16;

  typedef logic [CLS_W-1:0] ddr_qos_class_t;

  typedef struct packed {
    logic           vld;
    ddr_qos_class_t cls;
  } qos_tag_entry_t;

  typedef enum logic [0:0] {
    CRD_IDLE = 1'b0,
    CRD_SEND = 1'b1
  } crd_state_t;

endpackage

// File: rtl/ddr_rr_arbiter.sv
// ddr_rr_arbiter: round-robin pick over a request vector, starting the search
// at i_ptr; returns a one-hot grant, the granted index and an any-grant flag.
module ddr_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_k;

  // Walk the requests from the pointer upward (wrapping) and take the first hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N; i++) begin
      w_k = IDX_W'((int'(i_ptr) + i) % N);
      if (!o_any && i_req[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = w_k;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_qos_credit_return.sv
// ddr_qos_credit_return: tracks issued requests by tag, matches completions,
// and coalesces freed per-class credits into returns on a valid/ready channel.
module ddr_qos_credit_return
  import ddr_types_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_TAGS    = 16,
  parameter int MAX_OUTST   = 8,
  parameter int COALESCE    = DEF_COALESCE,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int TAG_W       = $clog2(NUM_TAGS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               iss_valid,
  output logic                               iss_ready,
  input  logic [TAG_W-1:0]                   iss_tag,
  input  logic [CLS_W-1:0]                   iss_class,
  input  logic                               cpl_valid,
  output logic                               cpl_ready,
  input  logic [TAG_W-1:0]                   cpl_tag,
  output logic                               crd_valid,
  input  logic                               crd_ready,
  output logic [CLS_W-1:0]                   crd_class,
  output logic [TAG_W:0]                     crd_count,
  output logic [NUM_CLASSES-1:0][TAG_W:0]    outst_cnt,
  output logic                               err_dup_tag,
  output logic                               err_unk_tag
);

  localparam int CNT_W = TAG_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  qos_tag_entry_t                       r_tbl [NUM_TAGS];
  logic [NUM_CLASSES-1:0][CNT_W-1:0]    r_outst;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]    r_pend;
  logic [NUM_CLASSES-1:0][TMR_W-1:0]    r_timer;
  crd_state_t                           r_state;
  ddr_qos_class_t                       r_rr_ptr;
  ddr_qos_class_t                       r_crd_class;
  logic [CNT_W-1:0]                     r_crd_count;
  logic                                 r_dup;
  logic                                 r_unk;

  logic [NUM_CLASSES-1:0][CNT_W-1:0]    w_outst_nxt;
  logic [NUM_CLASSES-1:0][CNT_W-1:0]    w_pend_nxt;
  logic [NUM_CLASSES-1:0][TMR_W-1:0]    w_timer_nxt;
  logic [NUM_CLASSES-1:0]               w_elig;
  logic [NUM_CLASSES-1:0]               w_grant;
  ddr_qos_class_t                       w_pick;
  logic                                 w_pick_any;
  logic [CNT_W-1:0]                     w_snap;
  crd_state_t                           w_state_nxt;
  logic                                 w_load;
  qos_tag_entry_t                       w_cpl_ent;
  logic                                 w_cpl_hit;
  logic                                 w_cpl_miss;
  logic                                 w_iss_fire;
  logic                                 w_tag_free;
  logic                                 w_iss_ok;
  logic                                 w_iss_dup;
  logic                                 w_crd_hs;

  // Completion lookup is evaluated before issue, so a tag freed this cycle is
  // immediately reusable by a same-cycle issue without a duplicate error.
  assign w_cpl_ent  = r_tbl[cpl_tag];
  assign w_cpl_hit  = cpl_valid & w_cpl_ent.vld;
  assign w_cpl_miss = cpl_valid & ~w_cpl_ent.vld;
  assign iss_ready  = (r_outst[iss_class] < CNT_W'(MAX_OUTST));
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_tag_free = ~r_tbl[iss_tag].vld | (w_cpl_hit & (cpl_tag == iss_tag));
  assign w_iss_ok   = w_iss_fire & w_tag_free;
  assign w_iss_dup  = w_iss_fire & ~w_tag_free;
  assign w_crd_hs   = (r_state == CRD_SEND) & crd_ready;

  assign cpl_ready   = 1'b1;
  assign crd_valid   = (r_state == CRD_SEND);
  assign crd_class   = r_crd_class;
  assign crd_count   = r_crd_count;
  assign outst_cnt   = r_outst;
  assign err_dup_tag = r_dup;
  assign err_unk_tag = r_unk;

  // A class wants a return once enough credits pile up or they have waited too long.
  always_comb begin
    w_elig = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      w_elig[c] = (r_pend[c] != '0) &&
                  ((r_pend[c] >= CNT_W'(COALESCE)) || (r_timer[c] == TMR_W'(TIMEOUT)));
    end
  end

  ddr_rr_arbiter #(
    .N     (NUM_CLASSES),
    .IDX_W (CLS_W)
  ) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_pick),
    .o_any   (w_pick_any)
  );

  // Per-class next values for outstanding, pending and wait timers, plus the
  // pending-count snapshot of whichever class the arbiter picked.
  always_comb begin
    w_outst_nxt = r_outst;
    w_pend_nxt  = r_pend;
    w_timer_nxt = r_timer;
    w_snap      = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      if (w_grant[c]) begin
        w_snap = w_snap | r_pend[c];
      end
      if (w_iss_ok && (iss_class == CLS_W'(c))) begin
        w_outst_nxt[c] = w_outst_nxt[c] + CNT_W'(1);
      end
      if (w_cpl_hit && (w_cpl_ent.cls == CLS_W'(c))) begin
        w_outst_nxt[c] = w_outst_nxt[c] - CNT_W'(1);
        w_pend_nxt[c]  = w_pend_nxt[c] + CNT_W'(1);
      end
      if (w_crd_hs && (r_crd_class == CLS_W'(c))) begin
        w_pend_nxt[c]  = w_pend_nxt[c] - r_crd_count;
        w_timer_nxt[c] = '0;
      end else if (r_pend[c] == '0) begin
        w_timer_nxt[c] = '0;
      end else if (r_timer[c] != TMR_W'(TIMEOUT)) begin
        w_timer_nxt[c] = r_timer[c] + TMR_W'(1);
      end
    end
  end

  // Return FSM: IDLE picks an eligible class and snapshots it, SEND holds until accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      CRD_IDLE: begin
        if (w_pick_any) begin
          w_load      = 1'b1;
          w_state_nxt = CRD_SEND;
        end
      end
      CRD_SEND: begin
        if (crd_ready) begin
          w_state_nxt = CRD_IDLE;
        end
      end
      default: w_state_nxt = CRD_IDLE;
    endcase
  end

  // Return FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CRD_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the return class/count on pick and advance the round-robin pointer on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crd_class <= '0;
      r_crd_count <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_load) begin
        r_crd_class <= w_pick;
        r_crd_count <= w_snap;
      end
      if (w_crd_hs) begin
        r_rr_ptr <= CLS_W'((int'(r_crd_class) + 1) % NUM_CLASSES);
      end
    end
  end

  // Tag table: completion clears first, then a legal issue claims the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_tbl[t] <= '0;
      end
    end else begin
      if (w_cpl_hit) begin
        r_tbl[cpl_tag].vld <= 1'b0;
      end
      if (w_iss_ok) begin
        r_tbl[iss_tag] <= '{vld: 1'b1, cls: iss_class};
      end
    end
  end

  // Per-class counters and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outst <= '0;
      r_pend  <= '0;
      r_timer <= '0;
      r_dup   <= 1'b0;
      r_unk   <= 1'b0;
    end else begin
      r_outst <= w_outst_nxt;
      r_pend  <= w_pend_nxt;
      r_timer <= w_timer_nxt;
      r_dup   <= w_iss_dup;
      r_unk   <= w_cpl_miss;
    end
  end

endmodule

// File: tb/tb_ddr_qos_credit_return.sv
// tb_ddr_qos_credit_return: directed scenarios plus randomized traffic checked
// against a behavioural model of the credit-return rules.
module tb_ddr_qos_credit_return;

  localparam int NC = 4;
  localparam int NT = 16;
  localparam int MO = 8;
  localparam int CO = 4;
  localparam int TO = 16;

  logic            clk;
  logic            rst_n;
  logic            iss_valid;
  logic            iss_ready;
  logic [3:0]      iss_tag;
  logic [1:0]      iss_class;
  logic            cpl_valid;
  logic            cpl_ready;
  logic [3:0]      cpl_tag;
  logic            crd_valid;
  logic            crd_ready;
  logic [1:0]      crd_class;
  logic [4:0]      crd_count;
  logic [3:0][4:0] outst_cnt;
  logic            err_dup_tag;
  logic            err_unk_tag;

  int n_checks;
  int n_fail;

  // behavioural model state
  bit m_vld [NT];
  int m_cls [NT];
  int m_outst [NC];
  int m_pend [NC];
  int m_timer [NC];
  bit m_sending;
  int m_crd_cls;
  int m_crd_cnt;
  int m_rr;
  bit m_dup;
  bit m_unk;

  ddr_qos_credit_return dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_tag     (iss_tag),
    .iss_class   (iss_class),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_tag     (cpl_tag),
    .crd_valid   (crd_valid),
    .crd_ready   (crd_ready),
    .crd_class   (crd_class),
    .crd_count   (crd_count),
    .outst_cnt   (outst_cnt),
    .err_dup_tag (err_dup_tag),
    .err_unk_tag (err_unk_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int t = 0; t < NT; t++) begin
      m_vld[t] = 0;
      m_cls[t] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      m_outst[c] = 0;
      m_pend[c]  = 0;
      m_timer[c] = 0;
    end
    m_sending = 0;
    m_crd_cls = 0;
    m_crd_cnt = 0;
    m_rr      = 0;
    m_dup     = 0;
    m_unk     = 0;
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int  old_pend [NC];
    int  old_timer [NC];
    bit  fire;
    bit  hit;
    bit  hs;
    int  ccls;
    old_pend  = m_pend;
    old_timer = m_timer;
    fire  = iss_valid && (m_outst[iss_class] < MO);
    hit   = cpl_valid && m_vld[cpl_tag];
    m_unk = cpl_valid && !m_vld[cpl_tag];
    ccls  = m_cls[cpl_tag];
    if (hit) begin
      m_vld[cpl_tag] = 0;
      m_outst[ccls]--;
      m_pend[ccls]++;
    end
    m_dup = fire && m_vld[iss_tag];
    if (fire && !m_dup) begin
      m_vld[iss_tag] = 1;
      m_cls[iss_tag] = int'(iss_class);
      m_outst[iss_class]++;
    end
    hs = m_sending && crd_ready;
    if (!m_sending) begin
      for (int i = 0; i < NC; i++) begin
        int c;
        c = (m_rr + i) % NC;
        if (!m_sending && old_pend[c] > 0 && (old_pend[c] >= CO || old_timer[c] == TO)) begin
          m_sending = 1;
          m_crd_cls = c;
          m_crd_cnt = old_pend[c];
        end
      end
    end else if (hs) begin
      m_pend[m_crd_cls] -= m_crd_cnt;
      m_rr      = (m_crd_cls + 1) % NC;
      m_sending = 0;
    end
    for (int c = 0; c < NC; c++) begin
      if (hs && c == m_crd_cls) m_timer[c] = 0;
      else if (old_pend[c] == 0) m_timer[c] = 0;
      else if (old_timer[c] < TO) m_timer[c] = old_timer[c] + 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    iss_valid = 0;
    iss_tag   = 0;
    iss_class = 0;
    cpl_valid = 0;
    cpl_tag   = 0;
    crd_ready = 0;
    rst_n     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic issue(input int tag, input int cls);
    iss_valid = 1;
    iss_tag   = 4'(tag);
    iss_class = 2'(cls);
    tick();
    iss_valid = 0;
  endtask

  task automatic complete(input int tag);
    cpl_valid = 1;
    cpl_tag   = 4'(tag);
    tick();
    cpl_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (outst_cnt !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outst: got %h expected 0", outst_cnt);
    end
    n_checks++;
    if (cpl_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_cpl_ready: got %b expected 1", cpl_ready);
    end
    n_checks++;
    if ({crd_valid, crd_class, crd_count, err_dup_tag, err_unk_tag} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got v=%b c=%0d n=%0d dup=%b unk=%b expected all 0",
               crd_valid, crd_class, crd_count, err_dup_tag, err_unk_tag);
    end
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_iss_ready: got %b expected 1", iss_ready);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    crd_ready = 1;
    for (int t = 0; t < 4; t++) issue(t, 1);
    n_checks++;
    if (outst_cnt[1] !== 5'd4) begin
      n_fail++;
      $display("[TB] FAIL coal_outst_full: got %0d expected 4", outst_cnt[1]);
    end
    for (int t = 0; t < 4; t++) complete(t);
    n_checks++;
    if (crd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL coal_early_valid: got %b expected 0", crd_valid);
    end
    tick();
    n_checks++;
    if (crd_valid !== 1'b1 || crd_class !== 2'd1 || crd_count !== 5'd4) begin
      n_fail++;
      $display("[TB] FAIL coal_return: got v=%b c=%0d n=%0d expected v=1 c=1 n=4",
               crd_valid, crd_class, crd_count);
    end
    n_checks++;
    if (outst_cnt[1] !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL coal_outst_empty: got %0d expected 0", outst_cnt[1]);
    end
    tick();
    n_checks++;
    if (crd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL coal_after_hs: got %b expected 0", crd_valid);
    end
  endtask

  task automatic test_timeout();
    int lat;
    do_reset();
    crd_ready = 1;
    lat = -1;
    issue(0, 2);
    complete(0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (crd_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat != TO + 1) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: got %0d cycles expected %0d", lat, TO + 1);
    end
    n_checks++;
    if (crd_class !== 2'd2 || crd_count !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL timeout_return: got c=%0d n=%0d expected c=2 n=1", crd_class, crd_count);
    end
  endtask

  task automatic test_outst_limit();
    do_reset();
    for (int t = 0; t < MO; t++) issue(t, 0);
    iss_valid = 1;
    iss_tag   = 4'd8;
    iss_class = 2'd0;
    #1;
    n_checks++;
    if (iss_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL limit_ready_low: got %b expected 0", iss_ready);
    end
    tick();
    n_checks++;
    if (outst_cnt[0] !== 5'd8) begin
      n_fail++;
      $display("[TB] FAIL limit_outst: got %0d expected 8", outst_cnt[0]);
    end
    iss_tag   = 4'd9;
    iss_class = 2'd3;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL limit_other_class: got %b expected 1", iss_ready);
    end
    tick();
    iss_valid = 0;
    n_checks++;
    if (outst_cnt[3] !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL limit_class3_outst: got %0d expected 1", outst_cnt[3]);
    end
    complete(0);
    iss_class = 2'd0;
    #1;
    n_checks++;
    if (iss_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL limit_ready_back: got %b expected 1", iss_ready);
    end
  endtask

  task automatic test_errors();
    do_reset();
    issue(5, 1);
    issue(5, 1);
    n_checks++;
    if (err_dup_tag !== 1'b1 || outst_cnt[1] !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL dup_pulse: got dup=%b outst=%0d expected dup=1 outst=1", err_dup_tag, outst_cnt[1]);
    end
    tick();
    n_checks++;
    if (err_dup_tag !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL dup_single: got %b expected 0", err_dup_tag);
    end
    complete(9);
    n_checks++;
    if (err_unk_tag !== 1'b1 || outst_cnt[1] !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL unk_pulse: got unk=%b outst=%0d expected unk=1 outst=1", err_unk_tag, outst_cnt[1]);
    end
    tick();
    n_checks++;
    if (err_unk_tag !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL unk_single: got %b expected 0", err_unk_tag);
    end
  endtask

  task automatic test_stall();
    int lat;
    do_reset();
    crd_ready = 0;
    for (int t = 0; t < 4; t++) issue(t, 0);
    for (int t = 4; t < 8; t++) issue(t, 2);
    issue(8, 0);
    for (int t = 0; t < 4; t++) complete(t);
    n_checks++;
    if (crd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_early_valid: got %b expected 0", crd_valid);
    end
    for (int k = 0; k < 10; k++) begin
      cpl_valid = (k < 5);
      cpl_tag   = (k < 4) ? 4'(4 + k) : 4'd8;
      tick();
      n_checks++;
      if (crd_valid !== 1'b1 || crd_class !== 2'd0 || crd_count !== 5'd4) begin
        n_fail++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b c=%0d n=%0d expected v=1 c=0 n=4",
                 k, crd_valid, crd_class, crd_count);
      end
    end
    cpl_valid = 0;
    crd_ready = 1;
    tick();
    n_checks++;
    if (crd_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL stall_gap: got %b expected 0", crd_valid);
    end
    tick();
    n_checks++;
    if (crd_valid !== 1'b1 || crd_class !== 2'd2 || crd_count !== 5'd4) begin
      n_fail++;
      $display("[TB] FAIL stall_second: got v=%b c=%0d n=%0d expected v=1 c=2 n=4",
               crd_valid, crd_class, crd_count);
    end
    tick();
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (crd_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    n_checks++;
    if (lat < 0 || crd_class !== 2'd0 || crd_count !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL stall_leftover: got wait=%0d c=%0d n=%0d expected c=0 n=1",
               lat, crd_class, crd_count);
    end
  endtask

  task automatic test_same_tag();
    do_reset();
    issue(3, 1);
    cpl_valid = 1;
    cpl_tag   = 4'd3;
    iss_valid = 1;
    iss_tag   = 4'd3;
    iss_class = 2'd1;
    tick();
    cpl_valid = 0;
    iss_valid = 0;
    n_checks++;
    if (err_dup_tag !== 1'b0 || err_unk_tag !== 1'b0 || outst_cnt[1] !== 5'd1) begin
      n_fail++;
      $display("[TB] FAIL same_tag: got dup=%b unk=%b outst=%0d expected 0 0 1",
               err_dup_tag, err_unk_tag, outst_cnt[1]);
    end
    complete(3);
    n_checks++;
    if (err_unk_tag !== 1'b0 || outst_cnt[1] !== 5'd0) begin
      n_fail++;
      $display("[TB] FAIL same_tag_still_valid: got unk=%b outst=%0d expected 0 0",
               err_unk_tag, outst_cnt[1]);
    end
  endtask

  task automatic test_random();
    int q[$];
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      q.delete();
      for (int t = 0; t < NT; t++) if (m_vld[t]) q.push_back(t);
      iss_valid = ($urandom_range(0, 99) < 45);
      iss_tag   = 4'($urandom_range(0, NT - 1));
      iss_class = 2'($urandom_range(0, NC - 1));
      cpl_valid = ($urandom_range(0, 99) < 45);
      if (q.size() > 0 && $urandom_range(0, 99) < 85) cpl_tag = 4'(q[$urandom_range(0, q.size() - 1)]);
      else cpl_tag = 4'($urandom_range(0, NT - 1));
      crd_ready = ($urandom_range(0, 99) < 65);
      #1;
      n_checks++;
      if (iss_ready !== (m_outst[iss_class] < MO)) begin
        n_fail++;
        $display("[TB] FAIL rnd_iss_ready cycle %0d: got %b expected %b", cyc, iss_ready, m_outst[iss_class] < MO);
      end
      tick();
      for (int c = 0; c < NC; c++) begin
        n_checks++;
        if (outst_cnt[c] !== 5'(m_outst[c])) begin
          n_fail++;
          $display("[TB] FAIL rnd_outst[%0d] cycle %0d: got %0d expected %0d", c, cyc, outst_cnt[c], m_outst[c]);
        end
      end
      n_checks++;
      if (err_dup_tag !== m_dup || err_unk_tag !== m_unk) begin
        n_fail++;
        $display("[TB] FAIL rnd_err cycle %0d: got dup=%b unk=%b expected dup=%b unk=%b",
                 cyc, err_dup_tag, err_unk_tag, m_dup, m_unk);
      end
      n_checks++;
      if (crd_valid !== m_sending) begin
        n_fail++;
        $display("[TB] FAIL rnd_crd_valid cycle %0d: got %b expected %b", cyc, crd_valid, m_sending);
      end else if (m_sending) begin
        n_checks++;
        if (crd_class !== 2'(m_crd_cls) || crd_count !== 5'(m_crd_cnt)) begin
          n_fail++;
          $display("[TB] FAIL rnd_crd cycle %0d: got c=%0d n=%0d expected c=%0d n=%0d",
                   cyc, crd_class, crd_count, m_crd_cls, m_crd_cnt);
        end
      end
    end
    // drop reset in the middle of traffic, away from a clock edge
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (crd_valid !== 1'b0 || outst_cnt !== '0 || cpl_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midop_reset: got v=%b outst=%h cpl_ready=%b expected 0 0 1",
               crd_valid, outst_cnt, cpl_ready);
    end
    do_reset();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_coalesce();
    test_timeout();
    test_outst_limit();
    test_errors();
    test_stall();
    test_same_tag();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
